// File: rtl/sync_link_pkg.sv
// Shared definitions for the synchronous CPU-to-peripheral send link:
// FSM state encoding and default parameter values.
package sync_link_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 16;
    localparam int DEF_CNT_W   = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t DRIVE   = 2'd1;
    localparam state_t RELEASE = 2'd2;
    localparam state_t ERROR   = 2'd3;

endpackage

// File: rtl/sync_link_fifo.sv
// First-word-fall-through FIFO for the send link; head is visible while not empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_link_fifo
    import sync_link_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign head    = mem_q[rd_ptr_q];
    // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q + LW'(do_push) - LW'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/sync_send_link.sv
// CPU-side transmitter: buffers pushed words and delivers them over a SEND/ACK
// four-phase handshake. Define SYNC_LINK_PARITY_EN to add the outPARITY output.
module sync_send_link
    import sync_link_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                     clk_link,
    input  logic                     rst_link,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     outSEND,
    output logic [DATA_W-1:0]        outDATA,
    input  logic                     inACK,
    output logic                     busy,
    output logic [CNT_W-1:0]         sent_count,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     err_timeout,
`ifdef SYNC_LINK_PARITY_EN
    output logic                     outPARITY,
`endif
    input  logic                     err_clr
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int LIMIT  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t              state_q, state_d;
    logic                send_q, send_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                err_q, err_d;
    logic                pop;
    logic                timeout_hit;
    logic [DATA_W-1:0]   fifo_head;
    logic                fifo_full;
    logic                fifo_empty;

    sync_link_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk_link),
        .rst_n     (rst_link),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign in_ready    = !fifo_full;
    assign outSEND     = send_q;
    assign outDATA     = data_q;
    assign sent_count  = count_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != IDLE) || !fifo_empty;
    assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_W'(LIMIT));

    // The awaited ACK level is tested before the timeout so a late ACK still wins.
    always_comb begin
        state_d = state_q;
        send_d  = send_q;
        data_d  = data_q;
        count_d = count_q;
        wait_d  = wait_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (!fifo_empty) begin
                    state_d = DRIVE;
                    send_d  = 1'b1;
                    data_d  = fifo_head;
                end
            end
            DRIVE: begin
                if (inACK) begin
                    state_d = RELEASE;
                    send_d  = 1'b0;
                    pop     = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    wait_d  = '0;
                end else if (timeout_hit) begin
                    state_d = ERROR;
                    send_d  = 1'b0;
                    err_d   = 1'b1;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            RELEASE: begin
                if (!inACK) begin
                    wait_d = '0;
                    if (!fifo_empty) begin
                        state_d = DRIVE;
                        send_d  = 1'b1;
                        data_d  = fifo_head;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timeout_hit) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ERROR: begin
                send_d = 1'b0;
                wait_d = '0;
                if (err_clr) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                send_d  = 1'b0;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_link or negedge rst_link) begin
        if (!rst_link) begin
            state_q <= IDLE;
            send_q  <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            send_q  <= send_d;
            data_q  <= data_d;
            count_q <= count_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

`ifdef SYNC_LINK_PARITY_EN
    logic parity_q, parity_d;

    assign parity_d  = ^data_d;
    assign outPARITY = parity_q;

    always_ff @(posedge clk_link or negedge rst_link) begin
        if (!rst_link) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`else
    // Parity output is not built in this configuration.
`endif

endmodule

// File: tb/tb_sync_send_link.sv
// Self-checking bench for sync_send_link: vector table, scoreboard of delivered
// words, and hand-written fill, timeout and mid-transfer reset sequences.
module tb_sync_send_link;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic              clk_link = 1'b0;
    logic              rst_link;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              outSEND;
    logic [DATA_W-1:0] outDATA;
    logic              inACK = 1'b0;
    logic              busy;
    logic [CNT_W-1:0]  sent_count;
    logic [LW-1:0]     fifo_level;
    logic              err_timeout;
    logic              err_clr;
`ifdef SYNC_LINK_PARITY_EN
    logic              outPARITY;
`endif

    int               checks = 0;
    int               errors = 0;
    logic [31:0]      expQ[$];
    int               expSent = 0;
    logic             ackMode = 1'b0;
    int               sendCnt = 0;
    logic [CNT_W-1:0] prevCount = '0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] expCount;
        logic        expParity;
    } vec_t;

    vec_t vecs[6];

    always #5 clk_link = ~clk_link;

    sync_send_link #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_link    (clk_link),
        .rst_link    (rst_link),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .outSEND     (outSEND),
        .outDATA     (outDATA),
        .inACK       (inACK),
        .busy        (busy),
        .sent_count  (sent_count),
        .fifo_level  (fifo_level),
        .err_timeout (err_timeout),
`ifdef SYNC_LINK_PARITY_EN
        .outPARITY   (outPARITY),
`endif
        .err_clr     (err_clr)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Peripheral: raise ACK after SEND has been seen high twice, drop it once SEND is low.
    always @(negedge clk_link) begin
        if (!rst_link) begin
            sendCnt = 0;
            inACK   = 1'b0;
        end else begin
            if (outSEND) sendCnt++;
            else sendCnt = 0;
            if (ackMode && outSEND && sendCnt >= 2) inACK = 1'b1;
            else if (!outSEND) inACK = 1'b0;
        end
    end

    // Every step of sent_count must deliver the oldest word still expected.
    always @(negedge clk_link) begin
        if (!rst_link) begin
            prevCount = sent_count;
        end else if (sent_count !== prevCount) begin
            checkOutput("count_step", 32'(sent_count), 32'(CNT_W'(prevCount + CNT_W'(1))));
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_delivery: got 0x%08h, expected no delivery", outDATA);
            end else begin
                checkOutput("delivered_word", outDATA, expQ.pop_front());
            end
            prevCount = sent_count;
        end
    end

    // Called at a negedge; returns at the negedge after the word was taken.
    task automatic applyStimulus(input logic [31:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 40) begin
            @(negedge clk_link);
            n++;
        end
        if (!in_ready) begin
            checkOutput("push_accept", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            expQ.push_back(d);
            @(negedge clk_link);
            in_valid = 1'b0;
        end
    endtask

    task automatic waitIdle(input string name, input logic [31:0] word, input bit checkStable);
        int n = 0;
        bit stable = 1'b1;
        while (busy && n < 80) begin
            if (checkStable && outDATA !== word) stable = 1'b0;
            @(negedge clk_link);
            n++;
        end
        checkOutput({name, "_idle"}, 32'(busy), 32'd0);
        if (checkStable) checkOutput({name, "_data_stable"}, 32'(stable), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  n;
        int  sendCycles;
        bit  sawSend;

        vecs[0] = '{32'hDEADBEEF, 32'd1, 1'b0};
        vecs[1] = '{32'h00000007, 32'd2, 1'b1};
        vecs[2] = '{32'h00000003, 32'd3, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 32'd4, 1'b0};
        vecs[4] = '{32'h00000000, 32'd5, 1'b0};
        vecs[5] = '{32'h80000001, 32'd6, 1'b0};

        in_valid = 1'b0;
        in_data  = '0;
        err_clr  = 1'b0;
        rst_link = 1'b1;
        #1 rst_link = 1'b0;
        repeat (5) @(negedge clk_link);
        checkOutput("rst_send", 32'(outSEND), 32'd0);
        checkOutput("rst_data", outDATA, 32'd0);
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_count", 32'(sent_count), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err_timeout), 32'd0);
        rst_link = 1'b1;
        @(negedge clk_link);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);

        $display("[TB] single-word vector table");
        ackMode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].data);
            checkOutput("tbl_level", 32'(fifo_level), 32'd1);
            checkOutput("tbl_send_early", 32'(outSEND), 32'd0);
            @(negedge clk_link);
            checkOutput("tbl_send", 32'(outSEND), 32'd1);
            checkOutput("tbl_data", outDATA, vecs[i].data);
`ifdef SYNC_LINK_PARITY_EN
            checkOutput("tbl_parity", 32'(outPARITY), 32'(vecs[i].expParity));
`endif
            expSent++;
            waitIdle("tbl", vecs[i].data, 1'b1);
            checkOutput("tbl_count", 32'(sent_count), vecs[i].expCount);
        end

        $display("[TB] fill sequence");
        ackMode = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(32'(i));
        end
        checkOutput("fill_ready", 32'(in_ready), 32'd0);
        checkOutput("fill_level4", 32'(fifo_level), 32'd4);
        checkOutput("fill_send", 32'(outSEND), 32'd1);
        checkOutput("fill_head", outDATA, 32'd1);
        in_valid = 1'b1;
        in_data  = 32'd5;
        repeat (2) @(negedge clk_link);
        checkOutput("fill_full_hold", 32'(fifo_level), 32'd4);
        ackMode = 1'b1;
        n = 0;
        while (fifo_level == LW'(4) && n < 20) begin
            @(negedge clk_link);
            n++;
        end
        checkOutput("fill_level3", 32'(fifo_level), 32'd3);
        checkOutput("fill_ready_back", 32'(in_ready), 32'd1);
        applyStimulus(32'd5);
        expSent += 5;
        waitIdle("fill", 32'd0, 1'b0);
        checkOutput("fill_count", 32'(sent_count), 32'(expSent));

        $display("[TB] timeout sequence");
        ackMode = 1'b0;
        applyStimulus(32'hA5A5A5A5);
        n = 0;
        sendCycles = 0;
        while (!err_timeout && n < 60) begin
            if (outSEND) sendCycles++;
            @(negedge clk_link);
            n++;
        end
        checkOutput("to_err", 32'(err_timeout), 32'd1);
        checkOutput("to_drive_cycles", 32'(sendCycles), 32'd16);
        checkOutput("to_send", 32'(outSEND), 32'd0);
        checkOutput("to_level", 32'(fifo_level), 32'd1);
        checkOutput("to_busy", 32'(busy), 32'd1);
        checkOutput("to_count", 32'(sent_count), 32'(expSent));
        err_clr = 1'b1;
        @(negedge clk_link);
        err_clr = 1'b0;
        checkOutput("to_err_clr", 32'(err_timeout), 32'd0);
        checkOutput("to_send_idle", 32'(outSEND), 32'd0);
        @(negedge clk_link);
        checkOutput("to_retry_send", 32'(outSEND), 32'd1);
        checkOutput("to_retry_data", outDATA, 32'hA5A5A5A5);
        ackMode = 1'b1;
        expSent++;
        waitIdle("to", 32'hA5A5A5A5, 1'b1);
        checkOutput("to_final_count", 32'(sent_count), 32'(expSent));

        $display("[TB] reset mid-transfer sequence");
        ackMode = 1'b0;
        applyStimulus(32'h11111111);
        applyStimulus(32'h22222222);
        applyStimulus(32'h33333333);
        checkOutput("mid_send", 32'(outSEND), 32'd1);
        checkOutput("mid_level", 32'(fifo_level), 32'd3);
        #2 rst_link = 1'b0;
        expQ.delete();
        expSent = 0;
        #1;
        checkOutput("mid_rst_send", 32'(outSEND), 32'd0);
        checkOutput("mid_rst_level", 32'(fifo_level), 32'd0);
        checkOutput("mid_rst_data", outDATA, 32'd0);
        checkOutput("mid_rst_count", 32'(sent_count), 32'd0);
        checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk_link);
        rst_link = 1'b1;
        ackMode  = 1'b1;
        sawSend  = 1'b0;
        repeat (20) begin
            @(negedge clk_link);
            if (outSEND) sawSend = 1'b1;
        end
        checkOutput("mid_no_send", 32'(sawSend), 32'd0);
        checkOutput("mid_no_count", 32'(sent_count), 32'(expSent));
        checkOutput("mid_busy", 32'(busy), 32'd0);

        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_send_link.md
Name: sync_send_link

Overview:
- Parametrised CPU-side transmitter for the synchronous CPU-to-peripheral link.
- Accepts words from the CPU core through a valid/ready push port and buffers them in a FIFO.
- Delivers each word to the peripheral over a SEND/ACK four-phase handshake on one shared clock.
- Adds buffering, ACK-based flow control, a delivered-word counter and a timeout error, none of which the single-word SEND/DATA link provides.

Parameters:
- DATA_W, 32, width of the data word on the input port and on outDATA.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
- TIMEOUT, 16, maximum cycles spent waiting for an ACK edge; 0 disables the timeout.
- CNT_W, 16, width of the sent_count counter.

Ports:
- clk_link  in  1  link clock, shared by CPU side and peripheral side.
- rst_link  in  1  reset; asynchronous assertion, active-low.
- in_valid  in  1  CPU has a word to push.
- in_data  in  DATA_W  word to push.
- in_ready  out  1  FIFO can accept a word.
- outSEND  out  1  handshake request to the peripheral.
- outDATA  out  DATA_W  word presented to the peripheral.
- inACK  in  1  peripheral acknowledge.
- busy  out  1  FSM is not in IDLE, or the FIFO is not empty.
- sent_count  out  CNT_W  number of completed transfers, modulo 2^CNT_W.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- err_timeout  out  1  sticky timeout flag.
- err_clr  in  1  clears err_timeout and leaves the ERROR state.

Behaviour:
- Reset values (rst_link=0): outSEND=0, outDATA=0, sent_count=0, fifo_level=0, err_timeout=0, busy=0, in_ready=1. FSM=IDLE. FIFO pointers are zeroed.
- Push rule: a word is written when in_valid && in_ready. in_ready = !full and is registered-derived.
  - When full, no push is taken, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave fifo_level unchanged.
- The FIFO is a first-word-fall-through; its head is visible combinationally to the FSM.
- FSM states and transitions:
  - IDLE: when the FIFO is not empty, go to DRIVE at the next edge; load outDATA from the head and set outSEND=1 (registered).
    - Latency: a push at edge N gives outSEND=1 after edge N+1.
  - DRIVE: outSEND=1 and outDATA held stable.
    - When inACK=1 is sampled, go to RELEASE, clear outSEND, pop the FIFO and increment sent_count.
  - RELEASE: outSEND=0 and outDATA held.
    - When inACK=0 is sampled, go to IDLE, or go directly to DRIVE with the next head if the FIFO is not empty after the pop.
    - Back-to-back throughput is therefore one word per 2 cycles plus peripheral latency.
  - ERROR: outSEND=0 and err_timeout=1; the word stays in the FIFO and no pop occurs.
    - When err_clr=1 is sampled, clear err_timeout and go to IDLE; the same word is retried.
- Timeout:
  - The wait counter resets on every state entry and increments each cycle spent in DRIVE or RELEASE while waiting.
  - When the count reaches TIMEOUT-1 without the awaited ACK level, go to ERROR.
  - If the ACK arrives in the same cycle as the limit, the ACK wins.
  - With TIMEOUT=0 there is no timeout.
- sent_count wraps from 2^CNT_W-1 to 0 silently.
- In ERROR, pushes are still accepted until the FIFO is full.
- An inACK=1 sampled in IDLE or ERROR is ignored.
- Reset mid-transfer: outputs return to their reset values immediately and FIFO contents are discarded.

Optional Feature:
- Macro: SYNC_LINK_PARITY_EN.
- Defined: adds output outPARITY (1 bit), registered alongside outDATA, equal to the even parity (XOR reduction) of outDATA; 0 at reset.
- Undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package sync_link_pkg holds:
  - the state typedef (IDLE, DRIVE, RELEASE, ERROR, 2-bit encoding 0..3);
  - default constants for DATA_W, DEPTH, TIMEOUT and CNT_W.
- One sub-module, sync_link_fifo: parametrised FWFT FIFO exposing full, empty and level.
- The FSM, timeout counter and sent_count stay in the top level.

Test Plan (DATA_W=32, DEPTH=4, TIMEOUT=16):
- Reset: hold rst_link=0 for 5 cycles, then release -> outSEND=0, outDATA=0, in_ready=1, fifo_level=0, sent_count=0.
- Single word: push 0xDEADBEEF; the peripheral model raises ACK 2 cycles after SEND and drops it 1 cycle after SEND falls -> outSEND=1 one cycle after the push, outDATA=0xDEADBEEF stable until IDLE, sent_count=1.
- Fill: push 5 words 0x1..0x5 back-to-back while inACK is held 0 -> in_ready=0 after the 4th push; fifo_level=4 (3 once the first word is popped); the 5th word is held by the CPU until in_ready returns, and delivery order is 0x1..0x5.
- Timeout: push 0xA5A5A5A5 and never assert ACK -> ERROR after 16 DRIVE cycles, err_timeout=1, outSEND=0, fifo_level=1; pulse err_clr -> the same word is resent.
- Reset mid-transfer: assert rst_link while in DRIVE with 3 words queued -> outSEND drops at once, fifo_level=0, and no delivery follows after release.
- Parity (macro defined): send 0x00000007 -> outPARITY=1; send 0x00000003 -> outPARITY=0.
